// File: rtl/md_ctrl.sv
// ---------------------------------------------------------------------------
// md_ctrl -- E-stage multiply/divide controller.
//
// This block owns the architectural HI/LO registers. It runs MULT/MULTU
// internally with a fixed-latency countdown. It sends DIV/DIVU to an
// external unsigned divide engine, and applies the sign correction for
// signed division here. It also serves MTHI/MTLO, and it requests a
// pipeline stall while any multiply or divide is in flight.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   op_valid, op       E-stage op strobe and code
//                      (000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                       100 MTHI, 101 MTLO; other codes are no-ops)
//   rs_data, rt_data   operands (rs_data is also the MTHI/MTLO source)
//   rd_sel, rd_data    MFHI/MFLO read port (0 = HI, 1 = LO), combinational
//   md_busy            stall request to the hazard unit
//   hi, lo             architectural HI/LO
//   eng_start          one-cycle start pulse to the divide engine
//   eng_a, eng_b       dividend/divisor magnitudes, held until next DIV
//   eng_busy           engine busy (low on the start cycle itself)
//   eng_hi, eng_lo     engine remainder/quotient (unsigned)
// ---------------------------------------------------------------------------
module md_ctrl #(
    parameter int MULT_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        md_busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        eng_start,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    input  logic        eng_busy,
    input  logic [31:0] eng_hi,
    input  logic [31:0] eng_lo
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MUL_WAIT  = 2'd1,
        DIV_START = 2'd2,
        DIV_WAIT  = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int            CW       = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MULT_LAT - 1);

    // Two's-complement negate when en is set. The result wraps to 32 bits,
    // so negating 0x80000000 gives 0x80000000 back.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [63:0]   prod_r;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;
    logic [31:0]   eng_a_r;
    logic [31:0]   eng_b_r;
    logic          eng_start_r;
    logic          busy_r;
    logic          qneg_r;
    logic          rneg_r;

    logic [63:0]   prod_s;
    logic          is_div_s;
    logic          rs_neg_s;
    logic          rt_neg_s;

    // Operand decode: product for the multiplies, sign bits for signed DIV.
    always_comb begin
        prod_s   = 64'd0;
        is_div_s = (op == OP_DIV);
        rs_neg_s = is_div_s & rs_data[31];
        rt_neg_s = is_div_s & rt_data[31];
        if (op == OP_MULT) begin
            // Sign-extend both operands to 64 bits. The low 64 bits of the
            // product are then the signed result.
            prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
        end else begin
            prod_s = {32'd0, rs_data} * {32'd0, rt_data};
        end
    end

    // Controller FSM: accepts ops, sequences MUL/DIV, and commits HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            prod_r      <= 64'd0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            eng_a_r     <= 32'd0;
            eng_b_r     <= 32'd0;
            eng_start_r <= 1'b0;
            busy_r      <= 1'b0;
            qneg_r      <= 1'b0;
            rneg_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                prod_r  <= prod_s;
                                cnt_r   <= CNT_INIT;
                                state_r <= MUL_WAIT;
                                busy_r  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                // A zero divisor is dropped silently: no issue, no stall.
                                if (rt_data != 32'd0) begin
                                    eng_a_r     <= neg_if(rs_data, rs_neg_s);
                                    eng_b_r     <= neg_if(rt_data, rt_neg_s);
                                    qneg_r      <= rs_neg_s ^ rt_neg_s;
                                    rneg_r      <= rs_neg_s;
                                    eng_start_r <= 1'b1;
                                    busy_r      <= 1'b1;
                                    state_r     <= DIV_START;
                                end
                            end
                            OP_MTHI: hi_r <= rs_data;
                            OP_MTLO: lo_r <= rs_data;
                            default: ;
                        endcase
                    end
                end
                MUL_WAIT: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        hi_r    <= prod_r[63:32];
                        lo_r    <= prod_r[31:0];
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                DIV_START: begin
                    eng_start_r <= 1'b0;
                    state_r     <= DIV_WAIT;
                end
                DIV_WAIT: begin
                    // eng_start is already low here, so a low busy means the result is valid.
                    if (!eng_busy) begin
                        lo_r    <= neg_if(eng_lo, qneg_r);
                        hi_r    <= neg_if(eng_hi, rneg_r);
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    eng_start_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign hi        = hi_r;
    assign lo        = lo_r;
    assign md_busy   = busy_r;
    assign eng_start = eng_start_r;
    assign eng_a     = eng_a_r;
    assign eng_b     = eng_b_r;
    // No bypass: a read sees only the committed registers.
    assign rd_data   = rd_sel ? lo_r : hi_r;

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Initiator side of the multiply/divide handshake; sits in the E stage.
- Owns the architectural HI/LO registers.
- Executes MULT/MULTU internally with a fixed-latency counter.
- Issues DIV/DIVU to the external unsigned divide engine over start/Busy/HI/LO, applying sign correction for DIV.
- Serves MTHI/MTLO/MFHI/MFLO and drives the pipeline stall.

Parameters:
- MULT_LAT, 5, cycles from MULT/MULTU accept to HI/LO commit (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  E-stage op present this cycle
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others = no-op
- rs_data  in  32  operand A / MTHI-MTLO source
- rt_data  in  32  operand B
- rd_sel  in  1  0 = read HI, 1 = read LO
- rd_data  out  32  combinational: rd_sel ? lo : hi
- md_busy  out  1  stall request to hazard unit
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- eng_start  out  1  one-cycle start pulse to divide engine
- eng_a  out  32  dividend magnitude, registered, stable while engine busy
- eng_b  out  32  divisor magnitude, registered, stable while engine busy
- eng_busy  in  1  engine busy (low on the start cycle itself)
- eng_hi  in  32  engine remainder, valid when eng_busy=0 and eng_start=0
- eng_lo  in  32  engine quotient, same validity

Behaviour:
- Reset, asynchronous and immediate, including mid-operation:
  - hi=lo=0, state=IDLE, md_busy=0, eng_start=0, eng_a=eng_b=0, counter=0, sign flags=0.
  - The engine shares this reset.
- States: IDLE, MUL_WAIT, DIV_START, DIV_WAIT. md_busy = (state != IDLE).
- Ops are accepted only in IDLE with op_valid=1. In any other state op_valid is ignored; the hazard unit holds the op while md_busy is high.
- IDLE, MTHI / MTLO:
  - hi (or lo) <= rs_data at the next edge; state stays IDLE; no stall.
  - Back-to-back MTHI/MTLO are legal every cycle.
- IDLE, MULT / MULTU:
  - Compute the 64-bit product at accept (signed for MULT, unsigned for MULTU) into an internal register.
  - counter <= MULT_LAT-1; go to MUL_WAIT.
- MUL_WAIT:
  - Decrement the counter each cycle.
  - When counter == 0: {hi,lo} <= product at that edge; go to IDLE.
  - md_busy is high for exactly MULT_LAT cycles after the accept edge.
- IDLE, DIV / DIVU with rt_data == 0:
  - No engine issue, hi/lo unchanged, stay IDLE, no stall.
- IDLE, DIV / DIVU with rt_data != 0:
  - eng_a <= |rs_data|, eng_b <= |rt_data|. Magnitudes apply for DIV only; DIVU passes raw values. |0x80000000| = 0x80000000 as unsigned.
  - Latch flags: qneg = DIV & (rs[31]^rt[31]); rneg = DIV & rs[31].
  - Go to DIV_START.
- DIV_START:
  - eng_start=1 for exactly this one cycle; go to DIV_WAIT.
- DIV_WAIT:
  - eng_start=0.
  - On the first cycle with eng_busy=0, commit lo <= qneg ? -eng_lo : eng_lo and hi <= rneg ? -eng_hi : eng_hi (two's complement, 32-bit wrap); go to IDLE.
  - With the 10-cycle engine, md_busy is high 12 cycles after the accept edge.
- Arithmetic edge cases:
  - 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0.
  - Remainder takes the sign of the dividend.
- eng_a/eng_b hold their values until the next DIV accept, because the engine result is combinational on its inputs.
- rd_data reflects hi/lo registers only, with no bypass.
  - MFHI in the cycle after an MTHI edge sees the new value.
  - The hazard unit must stall MFHI/MFLO while md_busy=1.

Test Plan:
- Reset, then MTHI rs=0x1234_5678, then MFHI (rd_sel=0) -> rd_data=0x12345678 the cycle after the MTHI edge; lo stays 0.
- MULTU 0xFFFFFFFF×2, MULT_LAT=5 -> md_busy high 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE; MULT -1×2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIVU 100/7 with the 10-cycle engine -> eng_start pulse 1 cycle after accept; eng_a=100, eng_b=7; md_busy high 12 cycles; then lo=14, hi=2.
- DIV -7/2 (0xFFFFFFF9/2) -> eng_a=7; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5/0 with hi=0xAA, lo=0xBB -> no eng_start, md_busy stays 0, hi/lo unchanged; op_valid MTLO during a DIV's DIV_WAIT -> ignored, lo = quotient only.
- Assert reset during DIV_WAIT cycle 4 -> md_busy=0 and hi=lo=0 immediately; next DIVU 9/3 completes normally with lo=3, hi=0.
